// File: rtl/systolic_operand_feeder.sv
// rtl/systolic_operand_feeder.sv - ping-pong operand buffer that replays NxN pairs as bursts into systolic_array
module systolic_operand_feeder #(
  parameter int DATAWIDTH    = 16,
  parameter int N_SIZE       = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [N_SIZE*DATAWIDTH-1:0]   s_a_col,
  input  logic [N_SIZE*DATAWIDTH-1:0]   s_b_row,
  output logic                          m_valid,
  output logic [N_SIZE*DATAWIDTH-1:0]   m_matrix_a,
  output logic [N_SIZE*DATAWIDTH-1:0]   m_matrix_b,
  input  logic                          arr_valid_out,
  output logic                          busy,
  output logic                          err_timeout
);

  localparam int W    = N_SIZE * DATAWIDTH;
  localparam int SW   = (N_SIZE > 1) ? $clog2(N_SIZE) : 1;
  localparam int CMAX = (N_SIZE > FLUSH_CYCLES) ? N_SIZE : FLUSH_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  localparam logic [SW-1:0] FILL_LAST = SW'(N_SIZE - 1);
  localparam logic [CW-1:0] SLOTS_C   = CW'(N_SIZE);
  localparam logic [CW-1:0] FLUSH_C   = CW'(FLUSH_CYCLES);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;

  logic [W-1:0]  bank_a [0:1][0:N_SIZE-1];
  logic [W-1:0]  bank_b [0:1][0:N_SIZE-1];
  logic [1:0]    full;
  logic [1:0]    full_nxt;
  logic          fill_ptr;
  logic          fill_ptr_nxt;
  logic [SW-1:0] fill_cnt;
  logic          iss_ptr;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] wait_cnt;
  logic          seen_high;
  logic          accept;
  logic          free_bank;

  assign accept    = s_valid && s_ready;
  // cnt == N in STREAM means slot N-1 has just been on the bus for its cycle
  assign free_bank = (state == ST_STREAM) && (cnt == SLOTS_C);

  // Next bank occupancy so s_ready can look one cycle ahead without a bubble
  always_comb begin
    full_nxt     = full;
    fill_ptr_nxt = fill_ptr;
    if (accept && (fill_cnt == FILL_LAST)) begin
      full_nxt[fill_ptr] = 1'b1;
      fill_ptr_nxt       = ~fill_ptr;
    end
    if (free_bank) begin
      full_nxt[iss_ptr] = 1'b0;
    end
  end

  // Fill-side bookkeeping: occupancy flags, fill pointer/slot and registered s_ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full     <= 2'b00;
      fill_ptr <= 1'b0;
      fill_cnt <= '0;
      s_ready  <= 1'b0;
    end else begin
      full     <= full_nxt;
      fill_ptr <= fill_ptr_nxt;
      s_ready  <= ~full_nxt[fill_ptr_nxt];
      if (accept) begin
        fill_cnt <= (fill_cnt == FILL_LAST) ? '0 : fill_cnt + 1'b1;
      end
    end
  end

  // Operand storage; contents are only meaningful while the bank is marked full
  always_ff @(posedge clk) begin
    if (accept) begin
      bank_a[fill_ptr][fill_cnt] <= s_a_col;
      bank_b[fill_ptr][fill_cnt] <= s_b_row;
    end
  end

  // Issue FSM: burst out a full bank, append flush zeros, then wait for the array to drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      iss_ptr     <= 1'b0;
      cnt         <= '0;
      wait_cnt    <= '0;
      seen_high   <= 1'b0;
      m_valid     <= 1'b0;
      m_matrix_a  <= '0;
      m_matrix_b  <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (full[iss_ptr]) begin
            state      <= ST_STREAM;
            busy       <= 1'b1;
            m_valid    <= 1'b1;
            m_matrix_a <= bank_a[iss_ptr][0];
            m_matrix_b <= bank_b[iss_ptr][0];
            cnt        <= CW'(1);
          end
        end
        ST_STREAM: begin
          if (cnt != SLOTS_C) begin
            m_matrix_a <= bank_a[iss_ptr][cnt[SW-1:0]];
            m_matrix_b <= bank_b[iss_ptr][cnt[SW-1:0]];
            cnt        <= cnt + 1'b1;
          end else begin
            iss_ptr    <= ~iss_ptr;
            m_matrix_a <= '0;
            m_matrix_b <= '0;
            if (FLUSH_CYCLES > 0) begin
              state <= ST_FLUSH;
              cnt   <= CW'(1);
            end else begin
              state     <= ST_WAIT;
              m_valid   <= 1'b0;
              wait_cnt  <= '0;
              seen_high <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          if (cnt != FLUSH_C) begin
            cnt <= cnt + 1'b1;
          end else begin
            state     <= ST_WAIT;
            m_valid   <= 1'b0;
            wait_cnt  <= '0;
            seen_high <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (seen_high && !arr_valid_out) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (wait_cnt == TMO_LAST) begin
            err_timeout <= 1'b1;
            state       <= ST_IDLE;
            busy        <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (arr_valid_out) begin
              seen_high <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// tb/tb_systolic_operand_feeder.sv - self-checking bench for systolic_operand_feeder
module tb_systolic_operand_feeder;

  localparam int DW = 16;
  localparam int N3 = 3;
  localparam int F3 = 2;
  localparam int W3 = N3 * DW;
  localparam int N2 = 2;
  localparam int F2 = 2;
  localparam int W2 = N2 * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W3-1:0] s_a_col = '0;
  logic [W3-1:0] s_b_row = '0;
  logic          m_valid;
  logic [W3-1:0] m_matrix_a;
  logic [W3-1:0] m_matrix_b;
  logic          arr_valid_out = 1'b0;
  logic          busy;
  logic          err_timeout;

  logic          s2_valid = 1'b0;
  logic          s2_ready;
  logic [W2-1:0] s2_a = '0;
  logic [W2-1:0] s2_b = '0;
  logic          m2_valid;
  logic [W2-1:0] m2_a;
  logic [W2-1:0] m2_b;
  logic          arr2_valid_out = 1'b0;
  logic          busy2;
  logic          err2;

  systolic_operand_feeder #(.DATAWIDTH(DW), .N_SIZE(N3), .FLUSH_CYCLES(F3), .TIMEOUT(10)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_a_col(s_a_col), .s_b_row(s_b_row), .m_valid(m_valid),
    .m_matrix_a(m_matrix_a), .m_matrix_b(m_matrix_b),
    .arr_valid_out(arr_valid_out), .busy(busy), .err_timeout(err_timeout)
  );

  systolic_operand_feeder #(.DATAWIDTH(DW), .N_SIZE(N2), .FLUSH_CYCLES(F2), .TIMEOUT(64)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .s_valid(s2_valid), .s_ready(s2_ready),
    .s_a_col(s2_a), .s_b_row(s2_b), .m_valid(m2_valid),
    .m_matrix_a(m2_a), .m_matrix_b(m2_b),
    .arr_valid_out(arr2_valid_out), .busy(busy2), .err_timeout(err2)
  );

  typedef struct {
    logic [W3-1:0] a;
    logic [W3-1:0] b;
    bit            exp_stall;
  } vec_t;

  typedef struct {
    logic [W2-1:0] a;
    logic [W2-1:0] b;
  } vec2_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
  } exp_t;

  vec_t  vecs [30];
  vec2_t v2   [2];
  exp_t  q3 [$];
  exp_t  q2 [$];
  logic [63:0] pa3 [N3];
  logic [63:0] pb3 [N3];
  logic [63:0] pa2 [N2];
  logic [63:0] pb2 [N2];
  int pn3 = 0;
  int pn2 = 0;

  int n_vec = 0;
  int n_err = 0;

  bit   arr_en = 1'b1;
  bit   arr_pending = 1'b0;
  int   arr_cnt = 0;
  int   run3 = 0;
  bit   prev_mv3 = 1'b0;
  logic [3:0] mv2_sh = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [W3-1:0] pack3(input int e0, input int e1, input int e2);
    return {DW'(e2), DW'(e1), DW'(e0)};
  endfunction

  // Scoreboard for the N=3 instance plus a model of the array's result window
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        run3++;
        if (arr_pending) chk("overlap_m_valid", 64'(m_valid), 64'(0));
        if (q3.size() == 0) begin
          chk("extra_burst_beat", 64'(m_valid), 64'(0));
        end else begin
          e = q3.pop_front();
          chk("m_matrix_a", 64'(m_matrix_a), e.a);
          chk("m_matrix_b", 64'(m_matrix_b), e.b);
        end
      end else if (prev_mv3) begin
        chk("burst_len", 64'(run3), 64'(N3 + F3));
        run3 = 0;
        if (arr_en) begin
          arr_pending = 1'b1;
          arr_cnt = 0;
        end
      end
      prev_mv3 = m_valid;
      if (s_valid && s_ready) begin
        pa3[pn3] = 64'(s_a_col);
        pb3[pn3] = 64'(s_b_row);
        pn3++;
        if (pn3 == N3) begin
          for (int k = 0; k < N3; k++) q3.push_back('{a: pa3[k], b: pb3[k]});
          for (int k = 0; k < F3; k++) q3.push_back('{a: 64'(0), b: 64'(0)});
          pn3 = 0;
        end
      end
      if (arr_pending) begin
        arr_cnt++;
        arr_valid_out = (arr_cnt >= 3 && arr_cnt <= 5);
        if (arr_cnt >= 6) arr_pending = 1'b0;
      end
      if (!rst_n) begin
        q3.delete();
        pn3 = 0;
        arr_pending = 1'b0;
        arr_valid_out = 1'b0;
        run3 = 0;
        prev_mv3 = 1'b0;
      end
    end
  end

  // Scoreboard for the N=2 instance; array response is m_valid delayed three cycles
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (m2_valid) begin
        if (q2.size() == 0) begin
          chk("extra_burst_beat2", 64'(m2_valid), 64'(0));
        end else begin
          e = q2.pop_front();
          chk("m2_matrix_a", 64'(m2_a), e.a);
          chk("m2_matrix_b", 64'(m2_b), e.b);
        end
      end
      if (s2_valid && s2_ready) begin
        pa2[pn2] = 64'(s2_a);
        pb2[pn2] = 64'(s2_b);
        pn2++;
        if (pn2 == N2) begin
          for (int k = 0; k < N2; k++) q2.push_back('{a: pa2[k], b: pb2[k]});
          for (int k = 0; k < F2; k++) q2.push_back('{a: 64'(0), b: 64'(0)});
          pn2 = 0;
        end
      end
      mv2_sh = {mv2_sh[2:0], m2_valid};
      arr2_valid_out = mv2_sh[3];
      if (!rst_n) begin
        q2.delete();
        pn2 = 0;
        mv2_sh = '0;
        arr2_valid_out = 1'b0;
      end
    end
  end

  task automatic send3(input int idx);
    int stalls = 0;
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_a_col = vecs[idx].a;
    s_b_row = vecs[idx].b;
    @(negedge clk);
    while (!s_ready && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    if (!s_ready) chk("s_ready_wait_bound", 64'(s_ready), 64'(1));
    chk($sformatf("stall_beat%0d", idx), 64'(stalls != 0), 64'(vecs[idx].exp_stall));
  endtask

  task automatic idle3();
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_a_col = W3'({$urandom(), $urandom()});
    s_b_row = W3'({$urandom(), $urandom()});
  endtask

  task automatic wait_mv(input bit level, input string name);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (m_valid !== level && k < 200);
    if (m_valid !== level) chk(name, 64'(m_valid), 64'(level));
  endtask

  task automatic wait_idle3();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((busy || q3.size() != 0 || arr_pending) && k < 300);
    if (busy || q3.size() != 0) chk("idle3_bound", 64'(q3.size()), 64'(0));
  endtask

  task automatic send2(input int idx, input int gap);
    int k = 0;
    repeat (gap) begin
      @(posedge clk); #1;
      s2_valid = 1'b0;
      s2_a = $urandom();
      s2_b = $urandom();
    end
    @(posedge clk); #1;
    s2_valid = 1'b1;
    s2_a = v2[idx].a;
    s2_b = v2[idx].b;
    do begin
      @(negedge clk);
      k++;
    end while (!s2_ready && k < 100);
    if (!s2_ready) chk("s2_ready_wait_bound", 64'(s2_ready), 64'(1));
  endtask

  task automatic wait_idle2();
    int k = 0;
    @(posedge clk); #1;
    s2_valid = 1'b0;
    do begin
      @(negedge clk);
      k++;
    end while ((busy2 || q2.size() != 0) && k < 300);
    if (busy2 || q2.size() != 0) chk("idle2_bound", 64'(q2.size()), 64'(0));
  endtask

  initial begin
    vecs[0] = '{a: pack3(1, 9, 6), b: pack3(4, 5, 9), exp_stall: 1'b0};
    vecs[1] = '{a: pack3(4, 2, 7), b: pack3(8, 7, 2), exp_stall: 1'b0};
    vecs[2] = '{a: pack3(8, 5, 3), b: pack3(7, 1, 3), exp_stall: 1'b0};
    for (int i = 3; i < 30; i++) begin
      vecs[i] = '{a: pack3(i * 3 + 1, i * 5 + 2, i * 7 + 3),
                  b: pack3(i * 11 + 4, 1000 + i, 40000 + i), exp_stall: 1'b0};
    end
    vecs[15].exp_stall = 1'b1;
    v2[0] = '{a: {16'd5, 16'd2}, b: {16'd2, 16'd4}};
    v2[1] = '{a: {16'd7, 16'd1}, b: {16'd5, 16'd8}};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_matrix_a", 64'(m_matrix_a), 64'(0));
    chk("rst_m_matrix_b", 64'(m_matrix_b), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err_timeout", 64'(err_timeout), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("s_ready_before_release_edge", 64'(s_ready), 64'(0));
    @(negedge clk);
    chk("s_ready_after_release", 64'(s_ready), 64'(1));

    // single pair
    for (int i = 0; i < 3; i++) send3(i);
    idle3();
    wait_mv(1'b1, "burst1_start_bound");
    wait_mv(1'b0, "burst1_end_bound");
    chk("busy_in_wait", 64'(busy), 64'(1));
    repeat (3) @(negedge clk);
    chk("busy_while_array_drains", 64'(busy), 64'(1));
    wait_idle3();
    chk("busy_after_drain", 64'(busy), 64'(0));

    // ping-pong, two pairs back to back
    for (int i = 3; i < 9; i++) send3(i);
    idle3();
    wait_idle3();

    // backpressure, three pairs offered continuously
    for (int i = 9; i < 18; i++) send3(i);
    idle3();
    wait_idle3();

    // watchdog with no array response
    arr_en = 1'b0;
    chk("err_before_timeout", 64'(err_timeout), 64'(0));
    for (int i = 18; i < 24; i++) send3(i);
    idle3();
    wait_mv(1'b1, "tmo_burst_start_bound");
    wait_mv(1'b0, "tmo_burst_end_bound");
    repeat (9) @(negedge clk);
    chk("err_at_wait_cycle10", 64'(err_timeout), 64'(0));
    @(negedge clk);
    chk("err_after_timeout", 64'(err_timeout), 64'(1));
    chk("busy_after_timeout", 64'(busy), 64'(0));
    wait_idle3();
    chk("err_sticky", 64'(err_timeout), 64'(1));
    arr_en = 1'b1;

    // reset during slot 1 of a burst
    for (int i = 24; i < 27; i++) send3(i);
    idle3();
    wait_mv(1'b1, "rst_burst_start_bound");
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_m_valid", 64'(m_valid), 64'(0));
    chk("mid_rst_m_matrix_a", 64'(m_matrix_a), 64'(0));
    chk("mid_rst_m_matrix_b", 64'(m_matrix_b), 64'(0));
    chk("mid_rst_s_ready", 64'(s_ready), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_err", 64'(err_timeout), 64'(0));
    @(negedge clk);
    chk("s_ready_after_mid_rst", 64'(s_ready), 64'(1));
    for (int i = 27; i < 30; i++) send3(i);
    idle3();
    wait_idle3();

    // N=2: continuous pair, then the same pair with random gaps, three times
    send2(0, 0);
    send2(1, 0);
    wait_idle2();
    for (int r = 0; r < 3; r++) begin
      send2(0, int'($urandom_range(1, 3)));
      send2(1, int'($urandom_range(1, 3)));
    end
    wait_idle2();
    chk("err2_clear", 64'(err2), 64'(0));

    chk("q3_leftover", 64'(q3.size()), 64'(0));
    chk("q2_leftover", 64'(q2.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
